// File: rtl/coef_ram_reader.sv
// Read sequencer for the synchronous-read coefficient RAM: fetches a wrapped burst
// of words and streams them out through a 2-entry skid buffer with valid/ready.
module coef_ram_reader #(
    parameter int  MEM_WIDTH = 32,
    parameter int  MEM_DEPTH = 1024,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      count,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_enable,
    output logic                 ram_write_en,
    output logic                 ram_reset,
    output logic [ADDR_W-1:0]    ram_address,
    input  logic [MEM_WIDTH-1:0] ram_data_out,
    output logic [MEM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t                state;
    logic [ADDR_W-1:0]     ptr;
    logic [ADDR_W-1:0]     last_addr;
    logic [ADDR_W:0]       remaining;
    logic                  inflight;
    logic                  inflight_last;
    logic [1:0]            occ;
    logic [MEM_WIDTH-1:0]  buf_data [2];
    logic                  buf_last [2];

    logic                  pop;
    logic                  issue;
    logic [2:0]            level;

    assign m_valid      = (occ != 2'd0);
    assign m_data       = buf_data[0];
    assign m_last       = m_valid && buf_last[0];
    assign pop          = m_valid && m_ready;
    assign level        = {1'b0, occ} + {2'b0, inflight};
    // A pop this cycle frees a slot, so an issue may ride on the same cycle.
    assign issue        = (state == READ) && (remaining != '0) && (level < (3'd2 + {2'b0, pop}));
    assign ram_enable   = issue;
    assign ram_address  = issue ? ptr : last_addr;
    assign ram_write_en = 1'b0;
    assign ram_reset    = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            last_addr     <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last[0]   <= 1'b0;
            buf_last[1]   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (remaining == (ADDR_W+1)'(1));
            occ           <= 2'(level - {2'b0, pop});

            if (issue) begin
                last_addr <= ptr;
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end

            // Head lives in entry 0; the landing word goes behind whatever survives the pop.
            if (inflight) begin
                if (pop && occ == 2'd2) begin
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                    buf_data[1] <= ram_data_out;
                    buf_last[1] <= inflight_last;
                end else if (pop || occ == 2'd0) begin
                    buf_data[0] <= ram_data_out;
                    buf_last[0] <= inflight_last;
                end else begin
                    buf_data[1] <= ram_data_out;
                    buf_last[1] <= inflight_last;
                end
            end else if (pop) begin
                buf_data[0] <= buf_data[1];
                buf_last[0] <= buf_last[1];
            end

            case (state)
                IDLE: if (start) begin
                    ptr       <= base_addr;
                    remaining <= count;
                    busy      <= 1'b1;
                    if (count == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                READ: if (issue && remaining == (ADDR_W+1)'(1)) state <= DRAIN;
                DRAIN: if (!inflight && occ == {1'b0, pop}) begin
                    state <= FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coef_ram_reader.sv
// Scoreboard bench for coef_ram_reader: a RAM model feeds the DUT, expected beats
// and read addresses are queued at command time and checked by a negedge monitor.
module tb_coef_ram_reader;
    localparam int W  = 32;
    localparam int D  = 1024;
    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          busy, done, ram_enable, ram_write_en, ram_reset;
    logic [AW-1:0] ram_address;
    logic [W-1:0]  ram_data_out;
    logic [W-1:0]  m_data;
    logic          m_valid, m_last;
    logic          m_ready;

    coef_ram_reader #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .ram_enable(ram_enable), .ram_write_en(ram_write_en),
        .ram_reset(ram_reset), .ram_address(ram_address), .ram_data_out(ram_data_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clock = ~clock;

    logic [W-1:0] mem [D];
    always @(posedge clock) if (ram_enable) ram_data_out <= mem[ram_address];

    typedef struct { logic [W-1:0] data; logic last; } beat_t;
    beat_t         sb_q[$];
    logic [AW-1:0] addr_q[$];

    int   checks = 0, passed = 0;
    int   beats = 0, en_count = 0, valid_count = 0;
    int   occ_m = 0, infl_m = 0;
    logic stall_prev = 1'b0, last_prev = 1'b0;
    logic [W-1:0] data_prev = '0;
    bit   rand_mode = 1'b0;
    logic ready_force = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clock) begin
        #2;
        m_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    always @(negedge clock) begin : monitor
        automatic logic pop = m_valid && m_ready;
        if (reset) begin
            occ_m = 0; infl_m = 0; stall_prev = 1'b0;
        end else begin
            chk("valid_vs_occ", m_valid, occ_m != 0);
            if (stall_prev)
                chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, last_prev, data_prev});
            if (ram_enable) begin
                en_count++;
                chk("issue_rule", (occ_m + infl_m - pop) < 2, 1'b1);
                if (addr_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_read: got address %0d expected no read", ram_address);
                end else chk("read_addr", ram_address, addr_q.pop_front());
            end
            if (m_valid) valid_count++;
            if (pop) begin
                beats++;
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", m_data);
                end else begin
                    automatic beat_t e = sb_q.pop_front();
                    chk("beat_data", m_data, e.data);
                    chk("beat_last", m_last, e.last);
                end
            end
            stall_prev = m_valid && !m_ready;
            data_prev  = m_data;
            last_prev  = m_last;
            occ_m      = occ_m + infl_m - pop;
            infl_m     = ram_enable;
        end
    end

    // Called just after a rising edge; that next edge accepts the command (E0).
    task automatic start_cmd(input int b, input int c, input bit expect_it);
        if (expect_it) begin
            for (int i = 0; i < c; i++) begin
                automatic logic [AW-1:0] a = AW'((b + i) % D);
                automatic beat_t bt;
                bt.data = mem[a];
                bt.last = (i == c - 1);
                addr_q.push_back(a);
                sb_q.push_back(bt);
            end
        end
        start = 1'b1; base_addr = AW'(b); count = (AW+1)'(c);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Watches cycles 1..maxc after E0; returns at the negedge of the done cycle.
    task automatic track(input int maxc, output int first_v, output int done_c,
                         output logic busy1, output logic en1, output logic busy_d);
        first_v = 0; done_c = 0; busy1 = 1'b0; en1 = 1'b0; busy_d = 1'b1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clock);
            if (k == 1) begin busy1 = busy; en1 = ram_enable; end
            if (m_valid && first_v == 0) first_v = k;
            if (done) begin done_c = k; busy_d = busy; break; end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int fv, dc, b0, v0, e0;
        logic bz1, en1, bzd;
        for (int i = 0; i < D; i++) mem[i] = 32'hA5A50000 | i;
        mem[0]  = 32'h3e96bb98; mem[1]  = 32'h3e34bc6a; mem[3]  = 32'h3f020c49;
        mem[7]  = 32'h3ad1b717; mem[8]  = 32'h3951b717; mem[10] = 32'h00000000;
        mem[12] = 32'h411cf5c2;
        m_ready = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ctrl", {busy, done, ram_enable, ram_write_en, ram_reset, m_valid, m_last}, 7'd0);
        chk("rst_addr", ram_address, 0);
        chk("rst_data", m_data, 0);
        @(posedge clock); #1; reset = 1'b0;
        @(posedge clock); #1;

        // basic burst with m_ready held high
        b0 = beats; v0 = valid_count;
        start_cmd(0, 13, 1);
        track(40, fv, dc, bz1, en1, bzd);
        chk("basic_busy_c1", bz1, 1'b1);
        chk("basic_en_c1", en1, 1'b1);
        chk("basic_first_valid", fv, 3);
        chk("basic_done_cycle", dc, 16);
        chk("basic_busy_at_done", bzd, 1'b0);
        chk("basic_beats", beats - b0, 13);
        chk("basic_valid_cycles", valid_count - v0, 13);
        chk("basic_sb_empty", sb_q.size(), 0);
        @(posedge clock); #1;

        // random backpressure
        rand_mode = 1'b1; b0 = beats;
        start_cmd(0, 13, 1);
        track(600, fv, dc, bz1, en1, bzd);
        chk("rand_done_seen", dc != 0, 1'b1);
        chk("rand_beats", beats - b0, 13);
        chk("rand_sb_empty", sb_q.size(), 0);
        rand_mode = 1'b0;
        @(posedge clock); #1;

        // long stall with the buffer full
        ready_force = 1'b0; b0 = beats;
        start_cmd(0, 13, 1);
        repeat (12) @(posedge clock);
        #1; ready_force = 1'b1;
        track(100, fv, dc, bz1, en1, bzd);
        chk("stall_done_seen", dc != 0, 1'b1);
        chk("stall_beats", beats - b0, 13);
        chk("stall_sb_empty", sb_q.size(), 0);
        @(posedge clock); #1;

        // address wrap
        rand_mode = 1'b1; b0 = beats;
        start_cmd(1022, 4, 1);
        track(300, fv, dc, bz1, en1, bzd);
        chk("wrap_done_seen", dc != 0, 1'b1);
        chk("wrap_beats", beats - b0, 4);
        chk("wrap_sb_empty", sb_q.size() + addr_q.size(), 0);
        rand_mode = 1'b0;
        @(posedge clock); #1;

        // zero count
        e0 = en_count; v0 = valid_count;
        start_cmd(0, 0, 1);
        track(10, fv, dc, bz1, en1, bzd);
        chk("zero_done_cycle", dc, 1);
        chk("zero_busy_c1", bz1, 1'b1);
        @(negedge clock);
        chk("zero_busy_c2", {busy, done}, 2'b00);
        chk("zero_no_reads", en_count - e0, 0);
        chk("zero_no_valid", valid_count - v0, 0);
        @(posedge clock); #1;

        // start while busy is ignored
        b0 = beats;
        start_cmd(0, 13, 1);
        repeat (5) @(posedge clock);
        #1;
        start_cmd(100, 3, 0);
        track(60, fv, dc, bz1, en1, bzd);
        chk("ign_done_seen", dc != 0, 1'b1);
        chk("ign_beats", beats - b0, 13);
        chk("ign_sb_empty", sb_q.size() + addr_q.size(), 0);
        @(posedge clock); #1;

        // reset mid-burst after beat 5, with the buffer filling behind a stall
        b0 = beats;
        start_cmd(0, 13, 1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (beats - b0 >= 6) break;
        end
        chk("rst_mid_reached", beats - b0, 6);
        @(posedge clock); #1; ready_force = 1'b0;
        @(posedge clock); #1; reset = 1'b1;
        sb_q.delete(); addr_q.delete();
        @(posedge clock); #1; reset = 1'b0; ready_force = 1'b1;
        @(negedge clock);
        chk("rstmid_ctrl", {busy, done, ram_enable, m_valid, m_last}, 5'd0);
        chk("rstmid_addr_data", {ram_address, m_data}, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("rstmid_quiet", {done, m_valid, ram_enable, busy}, 4'd0);
        end
        @(posedge clock); #1;
        b0 = beats;
        start_cmd(7, 2, 1);
        track(40, fv, dc, bz1, en1, bzd);
        chk("post_rst_done_cycle", dc, 5);
        chk("post_rst_beats", beats - b0, 2);
        chk("post_rst_sb_empty", sb_q.size(), 0);
        @(posedge clock); #1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
